// File: rtl/bp_be_issue_sequencer.sv
// rtl/bp_be_issue_sequencer.sv - issue-side sequencer: in-flight tracking, serialization/fence drains, stall counting
module bp_be_issue_sequencer #(
  parameter int inflight_max_p    = 4,
  parameter int stall_cnt_width_p = 16
) (
  input  logic                                 clk_i,
  input  logic                                 reset_n_i,
  input  logic                                 issue_v_i,
  input  logic                                 issue_serial_i,
  input  logic                                 issue_fence_i,
  output logic                                 issue_ready_o,
  output logic                                 dispatch_v_o,
  input  logic                                 dispatch_ready_i,
  input  logic                                 commit_v_i,
  input  logic                                 flush_i,
  output logic [$clog2(inflight_max_p+1)-1:0]  inflight_o,
  output logic                                 serial_busy_o,
  output logic                                 underflow_o,
  output logic [stall_cnt_width_p-1:0]         stall_cnt_o
);

  localparam int inflight_width_lp = $clog2(inflight_max_p+1);
  localparam logic [inflight_width_lp-1:0] inflight_max_lp = inflight_width_lp'(inflight_max_p);

  typedef enum logic [1:0] {
    READY  = 2'd0,
    DRAIN  = 2'd1,
    SERIAL = 2'd2
  } state_e;

  state_e                         state_q, state_d;
  logic [inflight_width_lp-1:0]   inflight_q, inflight_d;
  logic                           underflow_q, underflow_d;
  logic [stall_cnt_width_p-1:0]   stall_q, stall_d;

  logic barrier;
  logic empty;
  logic cond;

  assign barrier = issue_serial_i | issue_fence_i;
  assign empty   = (inflight_q == '0);

  // Barrier instructions wait for an empty pipe; nothing issues behind an uncommitted serial op.
  always_comb begin
    cond = 1'b0;
    unique case (state_q)
      READY:   cond = barrier ? empty : (inflight_q < inflight_max_lp);
      DRAIN:   cond = barrier & empty;
      SERIAL:  cond = 1'b0;
      default: cond = 1'b0;
    endcase
  end

  assign issue_ready_o = ~flush_i & dispatch_ready_i & cond;
  assign dispatch_v_o  = issue_v_i & issue_ready_o;

  always_comb begin
    inflight_d = inflight_q;
    if (flush_i) begin
      inflight_d = '0;
    end else if (dispatch_v_o & ~commit_v_i) begin
      inflight_d = inflight_q + inflight_width_lp'(1);
    end else if (~dispatch_v_o & commit_v_i & ~empty) begin
      inflight_d = inflight_q - inflight_width_lp'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = READY;
    end else begin
      unique case (state_q)
        READY: begin
          if (issue_v_i & issue_serial_i) begin
            state_d = dispatch_v_o ? SERIAL : DRAIN;
          end else if (issue_v_i & issue_fence_i & ~dispatch_v_o) begin
            state_d = DRAIN;
          end
        end
        DRAIN: begin
          // A dropped or non-barrier request means the held instruction went away.
          if (~issue_v_i | ~barrier) begin
            state_d = READY;
          end else if (dispatch_v_o) begin
            state_d = issue_serial_i ? SERIAL : READY;
          end
        end
        SERIAL: begin
          if (inflight_d == '0) state_d = READY;
        end
        default: state_d = READY;
      endcase
    end
  end

  assign underflow_d = underflow_q | (commit_v_i & empty);

  always_comb begin
    stall_d = stall_q;
    if (issue_v_i & ~issue_ready_o & ~(&stall_q)) begin
      stall_d = stall_q + stall_cnt_width_p'(1);
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= READY;
      inflight_q  <= '0;
      underflow_q <= 1'b0;
      stall_q     <= '0;
    end else begin
      state_q     <= state_d;
      inflight_q  <= inflight_d;
      underflow_q <= underflow_d;
      stall_q     <= stall_d;
    end
  end

  assign inflight_o    = inflight_q;
  assign serial_busy_o = (state_q != READY);
  assign underflow_o   = underflow_q;
  assign stall_cnt_o   = stall_q;

endmodule

// File: tb/tb_bp_be_issue_sequencer.sv
// tb/tb_bp_be_issue_sequencer.sv - directed and randomized checks of bp_be_issue_sequencer against a behavioural model
module tb_bp_be_issue_sequencer;

  localparam int MAX = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n = 1'b0;
  logic v = 1'b0, s = 1'b0, f = 1'b0, dr = 1'b0, c = 1'b0, fl = 1'b0;

  logic        issue_ready, dispatch_v, serial_busy, underflow;
  logic [2:0]  inflight;
  logic [15:0] stall_cnt;

  logic        issue_ready2, dispatch_v2, serial_busy2, underflow2;
  logic [2:0]  inflight2;
  logic [1:0]  stall_cnt2;

  bp_be_issue_sequencer #(.inflight_max_p(MAX), .stall_cnt_width_p(16)) dut (
    .clk_i(clk), .reset_n_i(reset_n), .issue_v_i(v), .issue_serial_i(s), .issue_fence_i(f),
    .issue_ready_o(issue_ready), .dispatch_v_o(dispatch_v), .dispatch_ready_i(dr),
    .commit_v_i(c), .flush_i(fl), .inflight_o(inflight), .serial_busy_o(serial_busy),
    .underflow_o(underflow), .stall_cnt_o(stall_cnt)
  );

  bp_be_issue_sequencer #(.inflight_max_p(MAX), .stall_cnt_width_p(2)) dut_narrow (
    .clk_i(clk), .reset_n_i(reset_n), .issue_v_i(v), .issue_serial_i(s), .issue_fence_i(f),
    .issue_ready_o(issue_ready2), .dispatch_v_o(dispatch_v2), .dispatch_ready_i(dr),
    .commit_v_i(c), .flush_i(fl), .inflight_o(inflight2), .serial_busy_o(serial_busy2),
    .underflow_o(underflow2), .stall_cnt_o(stall_cnt2)
  );

  int vectors = 0;
  int miscompares = 0;

  // Model: a serial op outstanding blocks everything; a blocked barrier means the sequencer is draining.
  int m_inflight;
  bit m_serial_out, m_drain, m_underflow;
  int m_stall, m_stall2;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_inflight = 0; m_serial_out = 0; m_drain = 0; m_underflow = 0; m_stall = 0; m_stall2 = 0;
  endtask

  function automatic bit model_ready();
    bit ok;
    if (m_serial_out)  ok = 0;
    else if (s || f)   ok = (m_inflight == 0);
    else               ok = !m_drain && (m_inflight < MAX);
    return !fl && dr && ok;
  endfunction

  // One clock: inputs applied at negedge+1, everything checked 1ns later, model advanced at posedge.
  task automatic cyc(input bit iv, input bit is, input bit ifn, input bit idr, input bit ic, input bit ifl);
    bit r, d;
    int nxt;
    v = iv; s = is; f = ifn; dr = idr; c = ic; fl = ifl;
    #1;
    r = model_ready();
    d = v && r;
    check("issue_ready", issue_ready, r);
    check("dispatch_v", dispatch_v, d);
    check("inflight", inflight, m_inflight);
    check("serial_busy", serial_busy, m_serial_out || m_drain);
    check("underflow", underflow, m_underflow);
    check("stall_cnt", stall_cnt, m_stall);
    check("stall_cnt_narrow", stall_cnt2, m_stall2);
    if (fl) nxt = 0;
    else begin
      nxt = m_inflight + (d ? 1 : 0) - (c ? 1 : 0);
      if (nxt < 0) nxt = 0;
    end
    @(posedge clk);
    if (c && m_inflight == 0) m_underflow = 1;
    if (v && !r) begin
      if (m_stall < 65535) m_stall++;
      if (m_stall2 < 3) m_stall2++;
    end
    m_drain      = !fl && v && (s || f) && !d && !m_serial_out;
    m_serial_out = !fl && ((d && s) || (m_serial_out && nxt != 0));
    m_inflight   = nxt;
    @(negedge clk);
    #1;
  endtask

  initial begin
    bit hold;
    model_reset();
    @(negedge clk);
    #1;
    reset_n = 1'b1;
    dr = 1'b1;
    #1;
    check("reset_inflight", inflight, 0);
    check("reset_busy", serial_busy, 0);
    check("reset_underflow", underflow, 0);
    check("reset_stall", stall_cnt, 0);
    check("reset_ready", issue_ready, 1);

    // Fill to depth, then one commit lets one more in.
    repeat (4) cyc(1, 0, 0, 1, 0, 0);
    check("full_inflight", inflight, 4);
    check("full_ready", issue_ready, 0);
    cyc(1, 0, 0, 1, 1, 0);
    cyc(1, 0, 0, 1, 0, 0);
    check("refill_inflight", inflight, 4);
    check("refill_stall", stall_cnt, 1);

    // Serial behind two in flight.
    repeat (2) cyc(0, 0, 0, 1, 1, 0);
    cyc(1, 1, 0, 1, 0, 0);
    check("serial_drain_busy", serial_busy, 1);
    repeat (2) cyc(1, 1, 0, 1, 1, 0);
    cyc(1, 1, 0, 1, 0, 0);
    check("serial_inflight", inflight, 1);
    check("serial_stall", stall_cnt, 4);
    cyc(1, 0, 0, 1, 1, 0);
    cyc(1, 0, 0, 1, 0, 0);
    check("post_serial_inflight", inflight, 1);
    check("post_serial_busy", serial_busy, 0);
    check("post_serial_stall", stall_cnt, 5);

    // Fence behind one in flight returns to READY, not SERIAL.
    cyc(1, 0, 1, 1, 0, 0);
    check("fence_busy", serial_busy, 1);
    cyc(1, 0, 1, 1, 1, 0);
    cyc(1, 0, 1, 1, 0, 0);
    check("fence_done_busy", serial_busy, 0);
    cyc(1, 0, 0, 1, 0, 0);
    check("after_fence_inflight", inflight, 2);

    // Flush in SERIAL with a simultaneous commit.
    repeat (2) cyc(0, 0, 0, 1, 1, 0);
    cyc(1, 1, 0, 1, 0, 0);
    cyc(1, 0, 0, 1, 1, 1);
    check("flush_dispatch_blocked", dispatch_v, 0);
    check("flush_inflight", inflight, 0);
    check("flush_busy", serial_busy, 0);
    check("flush_underflow", underflow, 0);

    // Commit on an empty pipe is sticky.
    cyc(0, 0, 0, 1, 1, 0);
    check("underflow_set", underflow, 1);
    check("underflow_inflight", inflight, 0);
    cyc(0, 0, 0, 1, 0, 0);
    check("underflow_sticky", underflow, 1);
    check("narrow_stall_sat", stall_cnt2, 3);

    // Asynchronous reset in the middle of a drain.
    repeat (3) cyc(1, 0, 0, 1, 0, 0);
    cyc(1, 1, 0, 1, 0, 0);
    check("pre_reset_inflight", inflight, 3);
    check("pre_reset_busy", serial_busy, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_inflight", inflight, 0);
    check("async_busy", serial_busy, 0);
    check("async_stall", stall_cnt, 0);
    check("async_underflow", underflow, 0);
    model_reset();
    @(negedge clk);
    #1;
    reset_n = 1'b1;

    // Random traffic; a blocked instruction is held with its flags.
    hold = 0;
    for (int i = 0; i < 3000; i++) begin
      bit nv, ns, nf, ndr, nc, nfl;
      if (hold) begin
        nv = 1; ns = s; nf = f;
      end else begin
        nv = ($urandom_range(0, 99) < 70);
        ns = ($urandom_range(0, 99) < 10);
        nf = !ns && ($urandom_range(0, 99) < 10);
      end
      ndr = ($urandom_range(0, 99) < 85);
      nc  = (m_inflight > 0) ? ($urandom_range(0, 99) < 40) : ($urandom_range(0, 99) < 2);
      nfl = ($urandom_range(0, 99) < 3);
      hold = 0;
      v = nv; s = ns; f = nf; dr = ndr; c = nc; fl = nfl;
      hold = nv && !model_ready();
      cyc(nv, ns, nf, ndr, nc, nfl);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
